// File: rtl/spm_arb_pkg.sv
// Shared encodings and bus widths for the scratchpad port-B arbiter.
// Imported by spm_arb and by anything that talks to its ports.
package spm_arb_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam logic MEM_ENABLE  = 1'b1;
  localparam logic MEM_DISABLE = 1'b0;

  localparam int SpmAddrBus  = 12;
  localparam int WordDataBus = 32;

  typedef enum logic {
    SPM_ARB_IDLE = 1'b0,
    SPM_ARB_ACK  = 1'b1
  } spm_arb_state_t;

  typedef enum logic {
    SPM_OWNER_MEM = 1'b0,
    SPM_OWNER_DMA = 1'b1
  } spm_owner_t;

endpackage

// File: rtl/spm_arb.sv
// SPM port-B arbiter: MEM stage vs DMA, fixed priority with DMA aging.
// Optional SPM_ARB_PERF_EN adds a saturating conflict counter output.
module spm_arb
  import spm_arb_pkg::*;
#(
  parameter int SPM_ADDR_W = SpmAddrBus,
  parameter int DATA_W     = WordDataBus,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_as_,
  input  logic                  mem_rw,
  input  logic [SPM_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_wr_data,
  output logic [DATA_W-1:0]     mem_rd_data,
  output logic                  mem_rdy_,
  input  logic                  dma_as_,
  input  logic                  dma_rw,
  input  logic [SPM_ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0]     dma_wr_data,
  output logic [DATA_W-1:0]     dma_rd_data,
  output logic                  dma_rdy_,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic [DATA_W-1:0]     spm_wr_data,
  input  logic [DATA_W-1:0]     spm_rd_data
`ifdef SPM_ARB_PERF_EN
  ,
  output logic [15:0]           conflict_cnt
`endif
);

  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  localparam bit AGING = (STARVE_MAX != 0);

  spm_arb_state_t state, state_nx;
  spm_owner_t     owner;
  logic [CW-1:0]  starve_cnt, starve_nx;

  logic mem_req, dma_req, both;
  logic grant, win_dma, aged;

  assign mem_req = (mem_as_ == ENABLE_);
  assign dma_req = (dma_as_ == ENABLE_);
  assign both    = mem_req && dma_req;
  assign aged    = AGING && (starve_cnt == SMAX);

  always_comb begin
    win_dma = 1'b0;
    unique case (1'b1)
      both:                win_dma = aged;
      !mem_req && dma_req: win_dma = 1'b1;
      default:             win_dma = 1'b0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    starve_nx = starve_cnt;
    unique case (state)
      SPM_ARB_IDLE: begin
        grant = mem_req || dma_req;
        if (grant) begin
          state_nx = SPM_ARB_ACK;
        end
        // Aging only counts real conflicts that DMA lost.
        if (grant && win_dma) begin
          starve_nx = '0;
        end else if (both && starve_cnt != SMAX) begin
          starve_nx = starve_cnt + CW'(1);
        end
      end
      SPM_ARB_ACK: begin
        state_nx = SPM_ARB_IDLE;
      end
      default: state_nx = SPM_ARB_IDLE;
    endcase
  end

  always_comb begin
    spm_as_     = DISABLE_;
    spm_rw      = READ;
    spm_addr    = mem_addr;
    spm_wr_data = mem_wr_data;
    if (grant) begin
      spm_as_ = ENABLE_;
      if (win_dma) begin
        spm_rw      = dma_rw;
        spm_addr    = dma_addr;
        spm_wr_data = dma_wr_data;
      end else begin
        spm_rw = mem_rw;
      end
    end
    if (reset) begin
      spm_as_ = DISABLE_;
    end
  end

  always_comb begin
    mem_rdy_    = DISABLE_;
    dma_rdy_    = DISABLE_;
    mem_rd_data = '0;
    dma_rd_data = '0;
    if (state == SPM_ARB_ACK) begin
      if (owner == SPM_OWNER_DMA) begin
        dma_rdy_    = ENABLE_;
        dma_rd_data = spm_rd_data;
      end else begin
        mem_rdy_    = ENABLE_;
        mem_rd_data = spm_rd_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SPM_ARB_IDLE;
      owner      <= SPM_OWNER_MEM;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      if (grant) begin
        owner <= win_dma ? SPM_OWNER_DMA : SPM_OWNER_MEM;
      end
    end
  end

`ifdef SPM_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (state == SPM_ARB_IDLE && both &&
                 conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
